// File: rtl/jpeg_stream_pkg.sv
// Shared JPEG stream definitions: marker prefix, stuff byte, EOI marker
// and the byte-stuffer output state encoding.
package jpeg_stream_pkg;

  localparam logic [7:0]  JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0]  JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [15:0] EOI_MARKER         = 16'hFFD9;

  typedef enum logic {
    S_PASS  = 1'b0,
    S_STUFF = 1'b1
  } stuff_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer next-state: natural binary rollover of the extended pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jpeg_ff_stuffer.sv
// JPEG byte stuffer: emits a 0x00 after every 0xFF of the entropy-coded
// stream. A byte FIFO absorbs the extra output cycles; vsync_out is held
// high until the FIFO and any pending stuff byte have drained.
// Optional macro JPEG_FF_STUFFER_STATS_EN adds a saturating stuff_count port.
module jpeg_ff_stuffer
  import jpeg_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_in_valid,
  input  logic        vsync_in,
  input  logic [7:0]  data_in,
  output logic        data_out_valid,
  output logic [7:0]  data_out,
  output logic        vsync_out,
`ifdef JPEG_FF_STUFFER_STATS_EN
  output logic [15:0] stuff_count,
`endif
  output logic        overflow
);

  stuff_state_e state_q, state_d;
  logic [7:0]   dout_q, dout_d;
  logic         vld_q, vld_d;
  logic         vsync_q, vsync_d;
  logic         ovf_q;
  logic         pop;
  logic         drop;
  logic         busy;
  logic [7:0]   fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (data_in_valid),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A byte is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop    = data_in_valid && fifo_full && !pop;
  assign busy    = !fifo_empty || (state_q == S_STUFF);
  assign vsync_d = vsync_in || busy;

  // Output FSM: pass bytes through, inserting one stuff cycle after each 0xFF.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_PASS: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          vld_d  = 1'b1;
          dout_d = fifo_dout;
          if (fifo_dout == JPEG_MARKER_PREFIX) state_d = S_STUFF;
        end
      end
      S_STUFF: begin
        vld_d   = 1'b1;
        dout_d  = JPEG_STUFF_BYTE;
        state_d = S_PASS;
      end
    endcase
  end

  // State, registered outputs, vsync extension and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_PASS;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      vsync_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      vsync_q <= vsync_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign data_out_valid = vld_q;
  assign data_out       = dout_q;
  assign vsync_out      = vsync_q;
  assign overflow       = ovf_q;

`ifdef JPEG_FF_STUFFER_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_base;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stuff counter restarts with each new frame (vsync_out rising) and
  // saturates; it is left untouched when the frame ends.
  always_comb begin
    cnt_base = (vsync_d && !vsync_q) ? 16'd0 : cnt_q;
    cnt_d    = (state_q == S_STUFF) ? sat_inc16(cnt_base) : cnt_base;
  end

  // Stuff counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign stuff_count = cnt_q;
`endif

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Bench for jpeg_ff_stuffer: directed and random byte streams, a queue-based
// reference model, and a monitor that checks every emitted byte in order.
module tb_jpeg_ff_stuffer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_in_valid;
  logic        vsync_in;
  logic [7:0]  data_in;
  logic        data_out_valid;
  logic [7:0]  data_out;
  logic        vsync_out;
  logic        overflow;
`ifdef JPEG_FF_STUFFER_STATS_EN
  logic [15:0] stuff_count;
`endif

  always #5 clock = ~clock;

  jpeg_ff_stuffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in_valid  (data_in_valid),
    .vsync_in       (vsync_in),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .vsync_out      (vsync_out),
`ifdef JPEG_FF_STUFFER_STATS_EN
    .stuff_count    (stuff_count),
`endif
    .overflow       (overflow)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  dout;
    logic        vsync;
    logic        ovf;
    logic [15:0] cnt;
  } snap_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         steps = 0;
  logic [7:0] exp_q[$];   // bytes the output stream must carry, in order
  logic [7:0] mfifo[$];   // model of the bytes buffered inside the block
  bit         m_stuff;    // a 0x00 is owed for the last 0xFF sent out
  snap_t      cur, prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one step per clock, from the block's stated rules.
  task automatic model_step();
    snap_t      nx;
    logic [7:0] b;
    bit         busy;
    bit         stuffed;
    nx      = cur;
    busy    = (mfifo.size() > 0) || m_stuff;
    stuffed = 0;
    if (reset) begin
      mfifo.delete();
      m_stuff  = 0;
      nx.vld   = 0;
      nx.dout  = 8'h00;
      nx.vsync = 0;
      nx.ovf   = 0;
      nx.cnt   = 16'd0;
    end else begin
      nx.vld = 0;
      if (m_stuff) begin
        exp_q.push_back(8'h00);
        nx.vld  = 1;
        nx.dout = 8'h00;
        m_stuff = 0;
        stuffed = 1;
      end else if (mfifo.size() > 0) begin
        b = mfifo.pop_front();
        exp_q.push_back(b);
        nx.vld  = 1;
        nx.dout = b;
        if (b == 8'hFF) m_stuff = 1;
      end
      if (data_in_valid) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(data_in);
        else nx.ovf = 1;
      end
      nx.vsync = vsync_in || busy;
      if (nx.vsync && !cur.vsync) nx.cnt = 16'd0;
      if (stuffed && nx.cnt != 16'hFFFF) nx.cnt = nx.cnt + 16'd1;
    end
    prev = cur;
    cur  = nx;
    steps++;
  endtask

  task automatic cyc(input bit v, input bit vs, input logic [7:0] d, input bit r);
    @(posedge clock);
    #1;
    data_in_valid = v;
    vsync_in      = vs;
    data_in       = d;
    reset         = r;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
  endtask

  // Monitor: per-cycle output state against the model, emitted bytes against the queue.
  always @(negedge clock) begin
    if (steps >= 2) begin
      check("data_out_valid", {31'd0, data_out_valid}, {31'd0, prev.vld});
      check("data_out", {24'd0, data_out}, {24'd0, prev.dout});
      check("vsync_out", {31'd0, vsync_out}, {31'd0, prev.vsync});
      check("overflow", {31'd0, overflow}, {31'd0, prev.ovf});
`ifdef JPEG_FF_STUFFER_STATS_EN
      check("stuff_count", {16'd0, stuff_count}, {16'd0, prev.cnt});
`endif
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("stream_byte", {24'd0, data_out}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    int n;
    bit vs;
    logic [7:0] d;
    data_in_valid = 0;
    vsync_in      = 0;
    data_in       = 8'h00;
    reset         = 1;
    m_stuff       = 0;
    cur  = '{vld: 1'b0, dout: 8'h00, vsync: 1'b0, ovf: 1'b0, cnt: 16'd0};
    prev = cur;

    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);

    // Plain stream, then a single stuffed byte.
    cyc(1, 1, 8'h12, 0); cyc(1, 1, 8'h34, 0); cyc(1, 1, 8'h56, 0);
    idle(6);
    cyc(1, 1, 8'hAB, 0); cyc(1, 1, 8'hFF, 0); cyc(1, 1, 8'hCD, 0);
    idle(8);

    // Back-to-back 0xFF at full rate, then a longer burst that overflows.
    for (int i = 0; i < 32; i++) cyc(1, 1, 8'hFF, 0);
    cyc(0, 0, 8'h00, 0);
    idle(60);
    for (int i = 0; i < 48; i++) cyc(1, 1, 8'hFF, 0);
    idle(80);
    cyc(0, 0, 8'h00, 1);

    // Fill with 0xFF then offer 0x77 while the FIFO is full and popping.
    for (int i = 0; i < 31; i++) cyc(1, 1, 8'hFF, 0);
    cyc(1, 1, 8'h77, 0);
    idle(60);
    cyc(0, 0, 8'h00, 1);

    // Drain: 8 bytes with four 0xFF, vsync_in falls right after the last one.
    cyc(1, 1, 8'h01, 0); cyc(1, 1, 8'hFF, 0); cyc(1, 1, 8'hFF, 0); cyc(1, 1, 8'h02, 0);
    cyc(1, 1, 8'hFF, 0); cyc(1, 1, 8'h03, 0); cyc(1, 1, 8'hFF, 0); cyc(1, 1, 8'h04, 0);
    idle(20);

    // Reset in the cycle the FSM enters the stuff state.
    cyc(1, 1, 8'hFF, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 1);
    idle(6);

    // Randomized frames with 0xFF-heavy data and occasional resets.
    vs = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) vs = ~vs;
      d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, vs, d,
          ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    // Bounded drain of everything still owed.
    n = 0;
    while ((exp_q.size() > 0) && n < 200) begin
      cyc(0, 0, 8'h00, 0);
      n++;
    end
    idle(3);
    check("drain_complete", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
